// File: rtl/alu_sched_pkg.sv
// Shared definitions for the ALU scheduler: FSM encoding, pass count and ALU opcodes.
// Build option: ALU_SCHED_TMR_EN selects three voted passes per op instead of one.
package alu_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

`ifdef ALU_SCHED_TMR_EN
  localparam int NPASS = 3;
`else
  localparam int NPASS = 1;
`endif

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

endpackage

// File: rtl/alu_sched_if.sv
// Bundle of requester, shared-ALU and response signals around the scheduler.
// slave is the scheduler side, master is the requester/ALU/consumer side.
interface alu_sched_if #(
  parameter int WIDTH = 32
);
  logic             req0_valid, req1_valid;
  logic             req0_ready, req1_ready;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]       req0_alucont, req1_alucont;
  logic [WIDTH-1:0] alu_a, alu_b;
  logic [2:0]       alu_alucont;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;
  logic             resp_valid, resp_ready, resp_id;
  logic [WIDTH-1:0] resp_result;
  logic             resp_zero;
  logic             mismatch;
  logic [7:0]       fault_cnt;

  modport slave (
    input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
    input  req0_alucont, req1_alucont, alu_result, alu_zero, resp_ready,
    output req0_ready, req1_ready, alu_a, alu_b, alu_alucont,
    output resp_valid, resp_id, resp_result, resp_zero, mismatch, fault_cnt
  );

  modport master (
    output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
    output req0_alucont, req1_alucont, alu_result, alu_zero, resp_ready,
    input  req0_ready, req1_ready, alu_a, alu_b, alu_alucont,
    input  resp_valid, resp_id, resp_result, resp_zero, mismatch, fault_cnt
  );
endinterface

// File: rtl/alu_sched_maj3.sv
// Bitwise 2-of-3 majority voter used on the result and zero-flag slots.
// Only needed when ALU_SCHED_TMR_EN is defined; the single-pass build has nothing to vote.
`ifdef ALU_SCHED_TMR_EN
module maj3 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] x0,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] x2,
  output logic [WIDTH-1:0] y
);
  assign y = (x0 & x1) | (x1 & x2) | (x0 & x2);
endmodule
`endif

// File: rtl/alu_sched.sv
// Round-robin scheduler of two requesters onto one shared combinational ALU.
// Build option: ALU_SCHED_TMR_EN runs each op three times and votes the results.
//
// state   | meaning
// IDLE    | waiting for a request, ready follows the grant
// EXEC    | operands held on the ALU, one pass captured per cycle
// RESP    | response presented until resp_ready
module alu_sched
  import alu_sched_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic        clk,
  input logic        reset,
  alu_sched_if.slave bus
);
  localparam logic [1:0] PASS_LAST = 2'(NPASS - 1);

  state_t           r_state, w_next;
  logic             r_last, r_id;
  logic [WIDTH-1:0] r_a, r_b;
  logic [2:0]       r_op;
  logic [1:0]       r_cnt;
  logic [WIDTH-1:0] r_res0;
  logic             r_z0;
  logic             w_gnt0, w_gnt1, w_accept, w_last_pass, w_resp_valid;

  // r_last = 1 means req1 was granted last, so req0 wins a tie
  assign w_gnt0      = bus.req0_valid & (~bus.req1_valid | r_last);
  assign w_gnt1      = bus.req1_valid & (~bus.req0_valid | ~r_last);
  assign w_accept    = (r_state == ST_IDLE) & (w_gnt0 | w_gnt1);
  assign w_last_pass = (r_state == ST_EXEC) & (r_cnt == 2'd0);

  // State register
  always_ff @(posedge clk) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next state and handshake outputs
  always_comb begin
    w_next         = r_state;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    w_resp_valid   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        bus.req0_ready = w_gnt0;
        bus.req1_ready = w_gnt1;
        if (w_gnt0 | w_gnt1) w_next = ST_EXEC;
      end
      ST_EXEC: if (w_last_pass) w_next = ST_RESP;
      ST_RESP: begin
        w_resp_valid = 1'b1;
        if (bus.resp_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Latch the granted request and count passes down to the last one
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_last <= 1'b1;
      r_id   <= 1'b0;
      r_a    <= '0;
      r_b    <= '0;
      r_op   <= '0;
      r_cnt  <= '0;
    end else if (w_accept) begin
      r_last <= w_gnt1;
      r_id   <= w_gnt1;
      r_a    <= w_gnt1 ? bus.req1_a : bus.req0_a;
      r_b    <= w_gnt1 ? bus.req1_b : bus.req0_b;
      r_op   <= w_gnt1 ? bus.req1_alucont : bus.req0_alucont;
      r_cnt  <= PASS_LAST;
    end else if ((r_state == ST_EXEC) && (r_cnt != 2'd0)) begin
      r_cnt <= r_cnt - 2'd1;
    end
  end

  assign bus.alu_a       = r_a;
  assign bus.alu_b       = r_b;
  assign bus.alu_alucont = r_op;
  assign bus.resp_valid  = w_resp_valid;
  assign bus.resp_id     = r_id;

`ifdef ALU_SCHED_TMR_EN
  logic [WIDTH-1:0] r_res1, r_res2;
  logic             r_z1, r_z2, r_mis;
  logic [7:0]       r_fcnt;
  logic [1:0]       w_slot;
  logic             w_diff;

  assign w_slot = PASS_LAST - r_cnt;
  // On the last pass the live ALU output is slot 2, so compare it before it lands
  assign w_diff = (r_res0 != r_res1) | (r_res1 != bus.alu_result) |
                  (r_z0 != r_z1) | (r_z1 != bus.alu_zero);

  // Capture each pass into its own slot
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_res0 <= '0; r_res1 <= '0; r_res2 <= '0;
      r_z0   <= 1'b0; r_z1 <= 1'b0; r_z2 <= 1'b0;
    end else if (r_state == ST_EXEC) begin
      case (w_slot)
        2'd0:    begin r_res0 <= bus.alu_result; r_z0 <= bus.alu_zero; end
        2'd1:    begin r_res1 <= bus.alu_result; r_z1 <= bus.alu_zero; end
        default: begin r_res2 <= bus.alu_result; r_z2 <= bus.alu_zero; end
      endcase
    end
  end

  // Disagreement pulse and saturating fault count, updated as the last pass lands
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_mis  <= 1'b0;
      r_fcnt <= 8'd0;
    end else begin
      r_mis <= w_last_pass & w_diff;
      if (w_last_pass && w_diff && (r_fcnt != 8'hFF)) r_fcnt <= r_fcnt + 8'd1;
    end
  end

  maj3 #(.WIDTH(WIDTH)) u_vote_res (
    .x0(r_res0), .x1(r_res1), .x2(r_res2), .y(bus.resp_result)
  );
  maj3 #(.WIDTH(1)) u_vote_zero (
    .x0(r_z0), .x1(r_z1), .x2(r_z2), .y(bus.resp_zero)
  );

  assign bus.mismatch  = r_mis;
  assign bus.fault_cnt = r_fcnt;
`else
  // Single pass: the captured slot is the response
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_res0 <= '0;
      r_z0   <= 1'b0;
    end else if (r_state == ST_EXEC) begin
      r_res0 <= bus.alu_result;
      r_z0   <= bus.alu_zero;
    end
  end

  assign bus.resp_result = r_res0;
  assign bus.resp_zero   = r_z0;
  assign bus.mismatch    = 1'b0;
  assign bus.fault_cnt   = 8'd0;
`endif

endmodule

// File: tb/tb_alu_sched.sv
// Self-checking bench for alu_sched: directed scenarios plus a randomized run
// against a transaction-level model (arbitration pointer, fixed latency, queued result).
module tb_alu_sched;
  import alu_sched_pkg::*;

  localparam int W   = 32;
  localparam int LAT = NPASS + 1;
  localparam logic [2:0] OPS [5] = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT};

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic tb_flip = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  alu_sched_if #(.WIDTH(W)) bus ();
  alu_sched #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [W-1:0] alu_ref(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    case (op)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_SLT:  return W'($signed(a) < $signed(b));
      default: return '0;
    endcase
  endfunction

  // Shared ALU model; tb_flip corrupts bit 0 of the current pass
  logic [W-1:0] w_alu;
  always_comb begin
    w_alu          = alu_ref(bus.alu_alucont, bus.alu_a, bus.alu_b) ^ W'(tb_flip);
    bus.alu_result = w_alu;
    bus.alu_zero   = (w_alu == '0);
  end

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic v, input logic [2:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b);
    if (id == 0) begin
      bus.req0_valid = v; bus.req0_alucont = op; bus.req0_a = a; bus.req0_b = b;
    end else begin
      bus.req1_valid = v; bus.req1_alucont = op; bus.req1_a = a; bus.req1_b = b;
    end
  endtask

  task automatic clear_reqs();
    set_req(0, 1'b0, 3'd0, '0, '0);
    set_req(1, 1'b0, 3'd0, '0, '0);
  endtask

  task automatic do_reset();
    clear_reqs();
    bus.resp_ready = 1'b1;
    tb_flip = 1'b0;
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  // One op from an idle scheduler with resp_ready=1; returns response and latency
  task automatic run_op(input int id, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit inject,
                        output logic [W-1:0] res, output logic z, output logic rid,
                        output int lat, output int nmis);
    lat = -1; nmis = 0; res = '0; z = 1'b0; rid = 1'b0;
    set_req(id, 1'b1, op, a, b);
    #1;
    check_eq("op_ready", (id == 0) ? bus.req0_ready : bus.req1_ready, 1);
    tick();
    set_req(id, 1'b0, op, a, b);
    for (int c = 1; c <= 12; c++) begin
      tb_flip = inject && (c == 2);
      #1;
      if (bus.mismatch) nmis++;
      if (bus.resp_valid) begin
        lat = c; res = bus.resp_result; z = bus.resp_zero; rid = bus.resp_id;
        break;
      end
      tick();
    end
    tb_flip = 1'b0;
    tick();
    #1;
    if (bus.mismatch) nmis++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] res;
    logic         z, rid;
    int           lat, nmis, seen, found;
    int           ids[$];
    // randomized-phase model state
    logic         p_valid[2];
    logic [W-1:0] p_a[2], p_b[2];
    logic [2:0]   p_op[2];
    logic         m_busy, m_ptr, e_id, g0, g1, exp_rv;
    int           m_age;
    logic [W-1:0] e_a, e_res;
    logic [2:0]   e_op;

    clear_reqs();
    bus.resp_ready = 1'b1;
    do_reset();

    // Reset state
    check_eq("rst_resp_valid", bus.resp_valid, 0);
    check_eq("rst_resp_id", bus.resp_id, 0);
    check_eq("rst_resp_result", bus.resp_result, 0);
    check_eq("rst_resp_zero", bus.resp_zero, 0);
    check_eq("rst_mismatch", bus.mismatch, 0);
    check_eq("rst_fault_cnt", bus.fault_cnt, 0);
    check_eq("rst_alu_a", bus.alu_a, 0);
    check_eq("rst_alu_b", bus.alu_b, 0);
    check_eq("rst_alu_op", bus.alu_alucont, 0);
    check_eq("rst_ready0", bus.req0_ready, 0);
    check_eq("rst_ready1", bus.req1_ready, 0);

    // ADD 5+7 from req0
    run_op(0, OP_ADD, 32'd5, 32'd7, 1'b0, res, z, rid, lat, nmis);
    check_eq("add_lat", lat, LAT);
    check_eq("add_res", res, 12);
    check_eq("add_zero", z, 0);
    check_eq("add_id", rid, 0);
    check_eq("add_mis", nmis, 0);

    // SUB equal operands gives zero; SLT signed compare
    run_op(1, OP_SUB, 32'h1234, 32'h1234, 1'b0, res, z, rid, lat, nmis);
    check_eq("sub_res", res, 0);
    check_eq("sub_zero", z, 1);
    check_eq("sub_id", rid, 1);
    run_op(0, OP_SLT, 32'hFFFF_FFFF, 32'd1, 1'b0, res, z, rid, lat, nmis);
    check_eq("slt_res", res, 1);
    check_eq("slt_zero", z, 0);

    // Both valid from reset: grants alternate starting with req0
    do_reset();
    set_req(0, 1'b1, OP_ADD, 32'd1, 32'd2);
    set_req(1, 1'b1, OP_ADD, 32'd10, 32'd20);
    ids.delete();
    for (int c = 0; c < 60 && ids.size() < 4; c++) begin
      #1;
      if (bus.resp_valid) begin
        check_eq("rr_id", bus.resp_id, ids.size() % 2);
        check_eq("rr_res", bus.resp_result, (ids.size() % 2) ? 30 : 3);
        ids.push_back(int'(bus.resp_id));
      end
      tick();
    end
    check_eq("rr_count", ids.size(), 4);

    // Response backpressure
    do_reset();
    bus.resp_ready = 1'b0;
    set_req(0, 1'b1, OP_AND, 32'h0000_F0F0, 32'h0000_FF00);
    set_req(1, 1'b1, OP_OR, 32'd3, 32'd4);
    #1;
    check_eq("bp_ready0", bus.req0_ready, 1);
    tick();
    set_req(0, 1'b0, 3'd0, '0, '0);
    found = 0;
    for (int c = 1; c <= 12; c++) begin
      #1;
      if (bus.resp_valid) begin found = c; break; end
      tick();
    end
    check_eq("bp_lat", found, LAT);
    for (int k = 0; k < 3; k++) begin
      check_eq("bp_valid", bus.resp_valid, 1);
      check_eq("bp_res", bus.resp_result, 32'h0000_F000);
      check_eq("bp_id", bus.resp_id, 0);
      check_eq("bp_ready1", bus.req1_ready, 0);
      tick();
      #1;
    end
    bus.resp_ready = 1'b1;
    #1;
    check_eq("bp_xfer_ready1", bus.req1_ready, 0);
    tick();
    check_eq("bp_idle_valid", bus.resp_valid, 0);
    check_eq("bp_idle_ready1", bus.req1_ready, 1);
    clear_reqs();

    // Reset during execution abandons the op
    do_reset();
    set_req(0, 1'b1, OP_ADD, 32'd5, 32'd7);
    #1;
    tick();
    clear_reqs();
    for (int c = 1; c < ((NPASS > 1) ? 2 : 1); c++) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check_eq("mid_rst_valid", bus.resp_valid, 0);
    check_eq("mid_rst_alu_a", bus.alu_a, 0);
    check_eq("mid_rst_res", bus.resp_result, 0);
    set_req(0, 1'b1, OP_ADD, 32'd1, 32'd1);
    #1;
    check_eq("mid_rst_idle", bus.req0_ready, 1);
    clear_reqs();
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (bus.resp_valid) seen++;
    end
    check_eq("mid_rst_no_resp", seen, 0);

`ifdef ALU_SCHED_TMR_EN
    // Single corrupted pass is outvoted and counted; count saturates at 255
    do_reset();
    run_op(0, OP_ADD, 32'd5, 32'd7, 1'b1, res, z, rid, lat, nmis);
    check_eq("tmr_res", res, 12);
    check_eq("tmr_mis", nmis, 1);
    check_eq("tmr_fcnt1", bus.fault_cnt, 1);
    for (int i = 2; i <= 300; i++) begin
      run_op(0, OP_ADD, 32'd5, 32'd7, 1'b1, res, z, rid, lat, nmis);
      if (i == 254) check_eq("tmr_fcnt254", bus.fault_cnt, 254);
      if (i == 255) check_eq("tmr_fcnt255", bus.fault_cnt, 255);
    end
    check_eq("tmr_fcnt_sat", bus.fault_cnt, 255);
    check_eq("tmr_res_last", res, 12);
`endif

    // Randomized traffic against the transaction model
    do_reset();
    p_valid[0] = 1'b0; p_valid[1] = 1'b0;
    m_busy = 1'b0; m_ptr = 1'b1; m_age = 0;
    e_id = 1'b0; e_a = '0; e_res = '0; e_op = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < 2; i++) begin
        if (!p_valid[i] && $urandom_range(0, 2) == 0) begin
          p_valid[i] = 1'b1;
          p_op[i] = OPS[$urandom_range(0, 4)];
          p_a[i] = $urandom();
          p_b[i] = ($urandom_range(0, 3) == 0) ? p_a[i] : $urandom();
        end
        set_req(i, p_valid[i], p_op[i], p_a[i], p_b[i]);
      end
      bus.resp_ready = ($urandom_range(0, 3) != 0);
      #1;
      g0 = !m_busy && p_valid[0] && (!p_valid[1] || m_ptr);
      g1 = !m_busy && p_valid[1] && (!p_valid[0] || !m_ptr);
      exp_rv = m_busy && (m_age >= LAT);
      check_eq("rnd_ready0", bus.req0_ready, g0);
      check_eq("rnd_ready1", bus.req1_ready, g1);
      check_eq("rnd_valid", bus.resp_valid, exp_rv);
      if (exp_rv) begin
        check_eq("rnd_id", bus.resp_id, e_id);
        check_eq("rnd_res", bus.resp_result, e_res);
        check_eq("rnd_zero", bus.resp_zero, e_res == '0);
      end else if (m_busy) begin
        check_eq("rnd_alu_a", bus.alu_a, e_a);
        check_eq("rnd_alu_op", bus.alu_alucont, e_op);
      end
      check_eq("rnd_mis", bus.mismatch, 0);
      check_eq("rnd_fcnt", bus.fault_cnt, 0);
      if (g0 || g1) begin
        e_id = g1; m_ptr = g1;
        e_a = p_a[g1]; e_op = p_op[g1];
        e_res = alu_ref(p_op[g1], p_a[g1], p_b[g1]);
        p_valid[g1] = 1'b0;
        m_busy = 1'b1; m_age = 1;
      end else if (exp_rv && bus.resp_ready) begin
        m_busy = 1'b0;
      end else if (m_busy) begin
        m_age++;
      end
      tick();
    end
    clear_reqs();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
